// File: rtl/relay_pkg.sv
// rtl/relay_pkg.sv - shared types and widths for the relay bus-reader registers
package relay_pkg;

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, HOLD} load_state_t;

  localparam int DATA_W = 8;

endpackage

// File: rtl/eight_bit_latch.sv
// rtl/eight_bit_latch.sv - enable-gated storage register shared by the bus-reading registers
module eight_bit_latch
  import relay_pkg::*;
#(
  parameter int N = DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_bus_loader.sv
// rtl/reg_bus_loader.sv - bus-reader register: settle-delayed capture of the data bus on a load level
module reg_bus_loader
  import relay_pkg::*;
#(
  parameter int N             = DATA_W,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ld,
  input  logic [N-1:0] bus_data,
  input  logic         bus_driven,
  output logic [N-1:0] content,
  output logic         done,
  output logic         busy,
  output logic         led_ld,
  output logic [N-1:0] led_content
);

  // Counter is loaded with one less than the settle time so that SETTLE lasts exactly SETTLE_CYCLES edges.
  localparam logic [3:0] SETTLE_INIT = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

  load_state_t  state, next_state;
  logic [3:0]   cnt, next_cnt;
  logic         cap_en;
  logic [N-1:0] cap_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      done  <= cap_en;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    cap_en     = 1'b0;
    case (state)
      IDLE: begin
        if (ld) begin
          if (SETTLE_CYCLES > 0) begin
            next_state = SETTLE;
            next_cnt   = SETTLE_INIT;
          end else begin
            next_state = CAPTURE;
          end
        end
      end
      SETTLE: begin
        if (!ld) begin
          next_state = IDLE;
        end else if (cnt == 4'd0) begin
          next_state = CAPTURE;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      CAPTURE: begin
        if (!ld) begin
          next_state = IDLE;
        end else begin
          cap_en     = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (!ld) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // An undriven relay bus floats to all zeros.
  assign cap_data = bus_driven ? bus_data : '0;

  eight_bit_latch #(.N(N)) u_store (
    .clk   (clk),
    .reset (reset),
    .en    (cap_en),
    .d     (cap_data),
    .q     (content)
  );

  assign busy        = (state == SETTLE) || (state == CAPTURE);
  assign led_ld      = ld;
  assign led_content = content;

endmodule

// File: tb/tb_reg_bus_loader.sv
// tb/tb_reg_bus_loader.sv - directed self-checking bench for reg_bus_loader (settle 2 and settle 0 builds)
module tb_reg_bus_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       ld, ldz;
  logic [7:0] bus_data;
  logic       bus_driven;

  logic [7:0] content, led_content;
  logic       done, busy, led_ld;
  logic [7:0] content_z, led_content_z;
  logic       done_z, busy_z, led_ld_z;

  int total = 0;
  int bad   = 0;
  int done_cnt;

  always #5 clk = ~clk;

  reg_bus_loader #(.N(8), .SETTLE_CYCLES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .ld          (ld),
    .bus_data    (bus_data),
    .bus_driven  (bus_driven),
    .content     (content),
    .done        (done),
    .busy        (busy),
    .led_ld      (led_ld),
    .led_content (led_content)
  );

  reg_bus_loader #(.N(8), .SETTLE_CYCLES(0)) dut_z (
    .clk         (clk),
    .reset       (reset),
    .ld          (ldz),
    .bus_data    (bus_data),
    .bus_driven  (bus_driven),
    .content     (content_z),
    .done        (done_z),
    .busy        (busy_z),
    .led_ld      (led_ld_z),
    .led_content (led_content_z)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step n edges, counting done pulses seen on the settle-2 instance.
  task automatic step_count(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if (done) done_cnt++;
    end
  endtask

  initial begin
    reset      = 1'b1;
    ld         = 1'b0;
    ldz        = 1'b0;
    bus_data   = 8'hFF;
    bus_driven = 1'b1;

    step();
    step();
    reset = 1'b0;
    check("rst_content", content, 8'h00);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_content_z", content_z, 8'h00);

    // basic load: edge 0 enters SETTLE, capture lands on edge 3
    bus_data = 8'hA5;
    ld       = 1'b1;
    check("led_ld", led_ld, 1'b1);
    step();
    check("e0_busy", busy, 1'b1);
    check("e0_content", content, 8'h00);
    step();
    step();
    check("e2_content", content, 8'h00);
    check("e2_done", done, 1'b0);
    step();
    check("e3_content", content, 8'hA5);
    check("e3_led_content", led_content, 8'hA5);
    check("e3_done", done, 1'b1);
    check("e3_busy", busy, 1'b0);
    step();
    check("e4_done", done, 1'b0);
    ld = 1'b0;
    step();

    // preload 3C, then a one-cycle ld must abort
    bus_data = 8'h3C;
    ld       = 1'b1;
    step_count(4);
    ld = 1'b0;
    step();
    check("pre_content", content, 8'h3C);
    bus_data = 8'h99;
    ld       = 1'b1;
    done_cnt = 0;
    step_count(1);
    ld = 1'b0;
    step_count(5);
    check("abort_content", content, 8'h3C);
    check("abort_done", done_cnt, 0);
    check("abort_busy", busy, 1'b0);

    // undriven bus reads zero
    bus_driven = 1'b0;
    bus_data   = 8'h77;
    ld         = 1'b1;
    done_cnt   = 0;
    step_count(6);
    check("undrv_content", content, 8'h00);
    check("undrv_done", done_cnt, 1);
    ld = 1'b0;
    step();
    bus_driven = 1'b1;

    // held ld never reloads
    bus_data = 8'h12;
    ld       = 1'b1;
    done_cnt = 0;
    step_count(4);
    check("held_first", content, 8'h12);
    bus_data = 8'h34;
    step_count(6);
    check("held_content", content, 8'h12);
    check("held_done", done_cnt, 1);
    ld = 1'b0;
    step();
    ld = 1'b1;
    step_count(4);
    check("reload_content", content, 8'h34);
    ld = 1'b0;
    step();

    // reset mid-SETTLE clears content and returns to IDLE
    bus_data = 8'h55;
    ld       = 1'b1;
    step();
    check("mid_busy", busy, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    ld    = 1'b0;
    check("mid_rst_content", content, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    step();

    // settle-0 build: capture on edge k+1
    bus_data = 8'hC3;
    ldz      = 1'b1;
    step();
    check("z_k_busy", busy_z, 1'b1);
    check("z_k_content", content_z, 8'h00);
    step();
    check("z_k1_content", content_z, 8'hC3);
    check("z_k1_done", done_z, 1'b1);
    step();
    check("z_k2_done", done_z, 1'b0);
    check("z_other_idle", content, 8'h00);
    ldz = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
